// File: rtl/fpu_pkg.sv
// Shared definitions for the add/sub issue path.
//   - Flag bit indices inside the 5-bit flag vector {inv, ovf, unf, inx, zer}.
//   - ADD_LATENCY: issue-to-result delay of the pipelined adder.
//   - Field slice positions of a packed IEEE-754 single-precision word.
//   - unpack_f(): splits a 32-bit word into sign/exponent/mantissa.
package fpu_pkg;

    localparam int FLG_INV = 4;
    localparam int FLG_OVF = 3;
    localparam int FLG_UNF = 2;
    localparam int FLG_INX = 1;
    localparam int FLG_ZER = 0;
    localparam int FLG_W   = 5;

    localparam int ADD_LATENCY = 2;

    localparam int F_SIGN    = 31;
    localparam int F_EXP_MSB = 30;
    localparam int F_EXP_LSB = 23;
    localparam int F_MAN_MSB = 22;
    localparam int F_MAN_LSB = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    function automatic float_t unpack_f(input logic [31:0] w);
        float_t f;
        f.sign = w[F_SIGN];
        f.exp  = w[F_EXP_MSB:F_EXP_LSB];
        f.man  = w[F_MAN_MSB:F_MAN_LSB];
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk      : clock
//   rst      : synchronous active-low reset
//   valid_i  : request vector {req1, req0}
//   grant_o  : one-hot (or zero) grant vector, combinational from valid_i
// last_grant_q holds the index of the most recent winner; on a contest the
// other requester wins. It resets to 1 so requester 0 wins the first contest.
// Grants are held off while reset is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_o      = 2'b00;
        last_grant_d = last_grant_q;
        if (rst) begin
            grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_q);
            grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_q);
        end
        if (|grant_o) begin
            last_grant_d = grant_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin issue controller for the pipelined single-precision add/sub.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   req_*_0 / req_*_1         : requester operand channels (valid/ready)
//   add_*  (out)              : operand fields and controls to the adder
//   add_Sz/Ez/Mz/flags (in)   : adder result, LATENCY cycles after issue
//   res_valid_0/1, res_data,
//   res_flags, res_tag        : result return, one-cycle strobe per op
//   sticky_flags_0/1, clr_*   : accumulated exception flags per requester
//   busy                      : any request pending or op in flight
// Handshake: a request transfers in any cycle where req_valid_x and
// req_ready_x are both high; req_ready_x is the grant and depends only on
// the current req_valid inputs. Results carry no backpressure.
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int LATENCY = ADD_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [31:0]      req_a_0,
    input  logic [31:0]      req_a_1,
    input  logic [31:0]      req_b_0,
    input  logic [31:0]      req_b_1,
    input  logic             req_op_0,
    input  logic             req_op_1,
    input  logic [1:0]       req_rm_0,
    input  logic [1:0]       req_rm_1,
    input  logic [TAG_W-1:0] req_tag_0,
    input  logic [TAG_W-1:0] req_tag_1,
    output logic             add_Sx,
    output logic             add_Sy,
    output logic             add_EOP,
    output logic             add_sub,
    output logic [7:0]       add_Ex,
    output logic [7:0]       add_Ey,
    output logic [22:0]      add_Mx,
    output logic [22:0]      add_My,
    output logic [1:0]       add_rm,
    input  logic             add_Sz,
    input  logic [7:0]       add_Ez,
    input  logic [22:0]      add_Mz,
    input  logic [4:0]       add_flags,
    output logic             res_valid_0,
    output logic             res_valid_1,
    output logic [31:0]      res_data,
    output logic [4:0]       res_flags,
    output logic [TAG_W-1:0] res_tag,
    output logic [4:0]       sticky_flags_0,
    output logic [4:0]       sticky_flags_1,
    input  logic             clr_flags_0,
    input  logic             clr_flags_1,
    output logic             busy
);

    logic [1:0] grant;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({req_valid_1, req_valid_0}),
        .grant_o (grant)
    );

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];

    // Issue decode: selected operands go straight to the adder; all zero when idle.
    logic             issue;
    logic             sel;
    float_t           fa;
    float_t           fb;
    logic             op_sel;
    logic [1:0]       rm_sel;
    logic [TAG_W-1:0] tag_sel;

    always_comb begin
        issue   = |grant;
        sel     = grant[1];
        fa      = '0;
        fb      = '0;
        op_sel  = 1'b0;
        rm_sel  = 2'b00;
        tag_sel = '0;
        if (issue) begin
            fa      = unpack_f(sel ? req_a_1 : req_a_0);
            fb      = unpack_f(sel ? req_b_1 : req_b_0);
            op_sel  = sel ? req_op_1 : req_op_0;
            rm_sel  = sel ? req_rm_1 : req_rm_0;
            tag_sel = sel ? req_tag_1 : req_tag_0;
        end
    end

    assign add_Sx  = fa.sign;
    assign add_Sy  = fb.sign;
    assign add_Ex  = fa.exp;
    assign add_Ey  = fb.exp;
    assign add_Mx  = fa.man;
    assign add_My  = fb.man;
    assign add_rm  = rm_sel;
    // Effective operation: subtract when signs differ for add or match for sub.
    assign add_EOP = fa.sign ^ fb.sign ^ op_sel;
    assign add_sub = add_EOP;

    // Tracker: one slot per pipeline stage, mirrors the adder's fixed latency.
    logic             trk_vld_q [LATENCY];
    logic             trk_id_q  [LATENCY];
    logic [TAG_W-1:0] trk_tag_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                trk_vld_q[i] <= 1'b0;
                trk_id_q[i]  <= 1'b0;
                trk_tag_q[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_id_q[i]  <= trk_id_q[i-1];
                trk_tag_q[i] <= trk_tag_q[i-1];
            end
            trk_vld_q[0] <= issue;
            trk_id_q[0]  <= sel;
            trk_tag_q[0] <= tag_sel;
        end
    end

    assign res_valid_0 = trk_vld_q[LATENCY-1] & ~trk_id_q[LATENCY-1];
    assign res_valid_1 = trk_vld_q[LATENCY-1] &  trk_id_q[LATENCY-1];
    assign res_tag     = trk_tag_q[LATENCY-1];
    assign res_data    = {add_Sz, add_Ez, add_Mz};
    assign res_flags   = add_flags;

    // Sticky flags: a clear removes old history but keeps a coincident result.
    logic [4:0] sticky0_q, sticky0_d;
    logic [4:0] sticky1_q, sticky1_d;

    always_comb begin
        sticky0_d = (clr_flags_0 ? 5'b0 : sticky0_q) | (res_valid_0 ? res_flags : 5'b0);
        sticky1_d = (clr_flags_1 ? 5'b0 : sticky1_q) | (res_valid_1 ? res_flags : 5'b0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky0_q <= '0;
            sticky1_q <= '0;
        end else begin
            sticky0_q <= sticky0_d;
            sticky1_q <= sticky1_d;
        end
    end

    assign sticky_flags_0 = sticky0_q;
    assign sticky_flags_1 = sticky1_q;

    logic inflight;
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight | trk_vld_q[i];
        end
    end

    assign busy = inflight | req_valid_0 | req_valid_1;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
module tb_fpu_addsub_arbiter;

    localparam int TAG_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic             req_valid_0, req_valid_1;
    logic             req_ready_0, req_ready_1;
    logic [31:0]      req_a_0, req_a_1, req_b_0, req_b_1;
    logic             req_op_0, req_op_1;
    logic [1:0]       req_rm_0, req_rm_1;
    logic [TAG_W-1:0] req_tag_0, req_tag_1;
    logic             add_Sx, add_Sy, add_EOP, add_sub;
    logic [7:0]       add_Ex, add_Ey;
    logic [22:0]      add_Mx, add_My;
    logic [1:0]       add_rm;
    logic             add_Sz;
    logic [7:0]       add_Ez;
    logic [22:0]      add_Mz;
    logic [4:0]       add_flags;
    logic             res_valid_0, res_valid_1;
    logic [31:0]      res_data;
    logic [4:0]       res_flags;
    logic [TAG_W-1:0] res_tag;
    logic [4:0]       sticky_flags_0, sticky_flags_1;
    logic             clr_flags_0, clr_flags_1;
    logic             busy;

    fpu_addsub_arbiter #(.TAG_W(TAG_W), .LATENCY(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_0    (req_valid_0),
        .req_valid_1    (req_valid_1),
        .req_ready_0    (req_ready_0),
        .req_ready_1    (req_ready_1),
        .req_a_0        (req_a_0),
        .req_a_1        (req_a_1),
        .req_b_0        (req_b_0),
        .req_b_1        (req_b_1),
        .req_op_0       (req_op_0),
        .req_op_1       (req_op_1),
        .req_rm_0       (req_rm_0),
        .req_rm_1       (req_rm_1),
        .req_tag_0      (req_tag_0),
        .req_tag_1      (req_tag_1),
        .add_Sx         (add_Sx),
        .add_Sy         (add_Sy),
        .add_EOP        (add_EOP),
        .add_sub        (add_sub),
        .add_Ex         (add_Ex),
        .add_Ey         (add_Ey),
        .add_Mx         (add_Mx),
        .add_My         (add_My),
        .add_rm         (add_rm),
        .add_Sz         (add_Sz),
        .add_Ez         (add_Ez),
        .add_Mz         (add_Mz),
        .add_flags      (add_flags),
        .res_valid_0    (res_valid_0),
        .res_valid_1    (res_valid_1),
        .res_data       (res_data),
        .res_flags      (res_flags),
        .res_tag        (res_tag),
        .sticky_flags_0 (sticky_flags_0),
        .sticky_flags_1 (sticky_flags_1),
        .clr_flags_0    (clr_flags_0),
        .clr_flags_1    (clr_flags_1),
        .busy           (busy)
    );

    // ---------------- adder stand-in ----------------
    // Two-register pipe carrying the hand-computed result the bench supplies
    // with each request (mdl_res / mdl_flg), captured on the issue edge.
    logic [31:0] mdl_res;
    logic [4:0]  mdl_flg;
    logic [36:0] pipe1, pipe2;

    always @(posedge clk) begin
        if (!rst) begin
            pipe1 <= '0;
            pipe2 <= '0;
        end else begin
            pipe1 <= (req_ready_0 | req_ready_1) ? {mdl_flg, mdl_res} : 37'd0;
            pipe2 <= pipe1;
        end
    end

    assign {add_flags, add_Sz, add_Ez, add_Mz} = pipe2;

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;
    // {id, tag, data}
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put0(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic [4:0] flg);
        req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op; req_rm_0 = 2'b00;
        req_tag_0 = tag; mdl_res = res; mdl_flg = flg;
    endtask

    task automatic put1(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic [4:0] flg);
        req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op; req_rm_1 = 2'b01;
        req_tag_1 = tag; mdl_res = res; mdl_flg = flg;
    endtask

    task automatic idle_all();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = '0; req_b_0 = '0; req_op_0 = 1'b0; req_rm_0 = '0; req_tag_0 = '0;
        req_a_1 = '0; req_b_1 = '0; req_op_1 = 1'b0; req_rm_1 = '0; req_tag_1 = '0;
        mdl_res = '0; mdl_flg = '0;
    endtask

    function automatic logic [71:0] add_bus();
        return {4'd0, add_Sx, add_Sy, add_EOP, add_sub, add_Ex, add_Ey, add_Mx, add_My, add_rm};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] t0, t1;
        logic [31:0] d;
        rst = 1'b0;
        clr_flags_0 = 1'b0;
        clr_flags_1 = 1'b0;
        idle_all();

        // Reset state
        repeat (3) tick();
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_res_valid", {res_valid_1, res_valid_0}, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_sticky", {sticky_flags_1, sticky_flags_0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_bus", add_bus(), 0);

        // Idle after reset release
        rst = 1'b1;
        tick();
        tick();
        chk("idle_add_bus", add_bus(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", {req_ready_1, req_ready_0}, 0);

        // Contest: both valid for 6 cycles, expect 0,1,0,1,0,1
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                t0 = 4'(i);
                t1 = 4'(8 + i);
                d  = 32'hC0DE_0000 + 32'(i);
                put0(32'h3F80_0000, 32'h3F80_0000, 1'b0, t0, d, 5'd0);
                put1(32'h4000_0000, 32'h4000_0000, 1'b0, t1, d, 5'd0);
            end else begin
                idle_all();
            end
            settle();
            if (i < 6) begin
                chk($sformatf("contest_grant_%0d", i), {req_ready_1, req_ready_0},
                    (i % 2 == 0) ? 72'd1 : 72'd2);
                exp_q.push_back((i % 2 == 0) ? {1'b0, t0, d} : {1'b1, t1, d});
            end
            if (i >= 2) begin
                exp_e = exp_q.pop_front();
                chk($sformatf("contest_rv_%0d", i), {res_valid_1, res_valid_0},
                    exp_e[36] ? 72'd2 : 72'd1);
                chk($sformatf("contest_tag_%0d", i), res_tag, exp_e[35:32]);
                chk($sformatf("contest_data_%0d", i), res_data, exp_e[31:0]);
            end
            tick();
        end
        chk("contest_drained", exp_q.size(), 0);

        // Single add: 1.0 + 2.0 = 3.0 from requester 0, tag 5
        put0(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, 32'h4040_0000, 5'b00000);
        settle();
        chk("add_ready0", {req_ready_1, req_ready_0}, 2'b01);
        chk("add_issue_bus", add_bus(),
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h80, 23'd0, 23'd0, 2'b00});
        chk("add_busy_issue", busy, 1);
        tick();
        idle_all();
        settle();
        chk("add_rv_c1", {res_valid_1, res_valid_0}, 0);
        chk("add_busy_flight", busy, 1);
        tick();
        chk("add_rv_c2", {res_valid_1, res_valid_0}, 2'b01);
        chk("add_data", res_data, 32'h4040_0000);
        chk("add_tag", res_tag, 5);
        chk("add_flags", res_flags, 0);
        tick();
        chk("add_rv_c3", {res_valid_1, res_valid_0}, 0);
        chk("add_sticky0", sticky_flags_0, 0);
        chk("add_busy_done", busy, 0);

        // Effective subtraction: 3.0 - 3.0 from requester 1 -> +0, zero flag
        put1(32'h4040_0000, 32'h4040_0000, 1'b1, 4'd9, 32'h0000_0000, 5'b00001);
        settle();
        chk("sub_ready1", {req_ready_1, req_ready_0}, 2'b10);
        chk("sub_eop", {add_EOP, add_sub}, 2'b11);
        chk("sub_rm", add_rm, 2'b01);
        tick();
        idle_all();
        tick();
        chk("sub_rv", {res_valid_1, res_valid_0}, 2'b10);
        chk("sub_data", res_data, 0);
        chk("sub_tag", res_tag, 9);
        chk("sub_flags", res_flags, 5'b00001);
        tick();
        chk("sub_sticky1", sticky_flags_1, 5'b00001);
        chk("sub_sticky0_untouched", sticky_flags_0, 0);

        // Build sticky_0 = 01000 (overflow), then clear coinciding with a 00010 result
        put0(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd3, 32'h7F80_0000, 5'b01000);
        tick();
        idle_all();
        tick();
        chk("ovf_flags", res_flags, 5'b01000);
        tick();
        chk("ovf_sticky0", sticky_flags_0, 5'b01000);
        put0(32'h3F80_0000, 32'h3080_0000, 1'b0, 4'd4, 32'h3F80_0000, 5'b00010);
        tick();
        idle_all();
        tick();
        clr_flags_0 = 1'b1;
        settle();
        chk("clr_rv", {res_valid_1, res_valid_0}, 2'b01);
        chk("clr_sticky_before", sticky_flags_0, 5'b01000);
        tick();
        clr_flags_0 = 1'b0;
        chk("clr_sticky_after", sticky_flags_0, 5'b00010);

        // Plain clear on requester 1
        clr_flags_1 = 1'b1;
        tick();
        clr_flags_1 = 1'b0;
        chk("clr1_sticky", sticky_flags_1, 0);
        chk("clr1_sticky0_kept", sticky_flags_0, 5'b00010);

        // Reset mid-flight: issue at c, reset at c+1, nothing at c+2
        put0(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd7, 32'h4000_0000, 5'b00000);
        settle();
        chk("rmf_issue", req_ready_0, 1);
        tick();
        idle_all();
        rst = 1'b0;
        tick();
        chk("rmf_rv", {res_valid_1, res_valid_0}, 0);
        chk("rmf_busy", busy, 0);
        chk("rmf_tag", res_tag, 0);
        chk("rmf_sticky", {sticky_flags_1, sticky_flags_0}, 0);
        chk("rmf_add_bus", add_bus(), 0);
        tick();
        chk("rmf_rv_late", {res_valid_1, res_valid_0}, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("rmf_rv_after", {res_valid_1, res_valid_0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
# fpu_addsub_arbiter

Two-port round-robin arbiter and issue controller for the pipelined single-precision add/sub unit (`Top_Add_Sub`). It accepts operand pairs from two requesters over valid/ready handshakes and issues at most one operation per cycle. It tracks in-flight operations through the unit's fixed latency, steers each result and its flags back to the originating requester with its tag, and keeps per-requester sticky exception flags.

## Interface
Parameters:
- `TAG_W`, 4: width of the requester tag carried with each operation.
- `LATENCY`, 2: cycles from issue to adder output; fixed by the adder's input and output registers.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid_0/1`  in  1  request present.
- `req_ready_0/1`  out  1  request accepted this cycle (grant).
- `req_a_0/1`, `req_b_0/1`  in  32  IEEE-754 single-precision operands {S, E[7:0], M[22:0]}.
- `req_op_0/1`  in  1  0 = add, 1 = subtract.
- `req_rm_0/1`  in  2  rounding mode, passed through.
- `req_tag_0/1`  in  TAG_W  opaque tag.
- `add_Sx`, `add_Sy`, `add_EOP`, `add_sub`  out  1  adder controls.
- `add_Ex`, `add_Ey`  out  8  adder exponents.
- `add_Mx`, `add_My`  out  23  adder mantissas.
- `add_rm`  out  2  adder rounding mode.
- `add_Sz`  in  1  adder result sign.
- `add_Ez`  in  8  adder result exponent.
- `add_Mz`  in  23  adder result mantissa.
- `add_flags`  in  5  {invalid, overflow, underflow, inexact, zero}.
- `res_valid_0/1`  out  1  one-cycle result strobe for requester 0/1.
- `res_data`  out  32  {add_Sz, add_Ez, add_Mz}; shared by both requesters.
- `res_flags`  out  5  `add_flags` aligned with `res_data`.
- `res_tag`  out  TAG_W  tag of the returning operation.
- `sticky_flags_0/1`  out  5  accumulated flags per requester.
- `clr_flags_0/1`  in  1  clear that requester's sticky flags.
- `busy`  out  1  any request valid or any operation in flight.

## Operation
- **Arbitration:** round-robin between the two requesters, using a `last_grant` register.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - `last_grant` updates on every grant.
  - Reset sets `last_grant` = 1, so requester 0 wins the first contest.
- **Ready:** `req_ready_i` = `grant_i`, combinational from `req_valid`. No bubbles: back-to-back issue every cycle is allowed.
- **Issue decode:** on grant, the selected operand fields drive `add_*` combinationally.
  - `add_EOP` = Sa ^ Sb ^ op.
  - `add_sub` = `add_EOP`.
- **Idle drive:** with no grant, all `add_*` outputs are driven to 0.
- **Tracker:** a LATENCY-deep shift register holds {valid, id, tag} per issue slot and shifts every cycle. Its stage LATENCY-1 output drives `res_valid_id` and `res_tag`.
- **Result outputs:** `res_data` and `res_flags` are wired from the adder outputs. They are meaningful only while a `res_valid` is high.
- **Sticky flags:** `sticky_i` ≤ (`clr_flags_i` ? 0 : `sticky_i`) | (`res_valid_i` ? `res_flags` : 0). When clear and a new result coincide, the old value is cleared and the new flags are kept.
- **Busy:** `busy` = |tracker valids | `req_valid_0` | `req_valid_1`.
- **Reset:** reset mid-operation drops all in-flight results; no `res_valid` is produced for them. The adder is reset from the same source.

## Timing
- **Reset values:** `req_ready` 0, `res_valid` 0, `res_tag` 0, `sticky_flags` 0, `busy` 0, `add_*` 0.
- **Latency:** a grant in cycle c produces `res_valid_id` in exactly cycle c+2 (generally c+LATENCY). Results are never reordered.
- **Throughput:** one operation per cycle. A sustained contest alternates grants 0, 1, 0, 1, and so on.
- **Result strobe:** each result is asserted for exactly one cycle. There is no result backpressure; requesters must accept every result.

## Structure
- **Shared package `fpu_pkg`:** flag bit indices (INV=4, OVF=3, UNF=2, INX=1, ZER=0), `ADD_LATENCY` = 2, and the packed-float field slice constants.
- **Sub-module `rr_arb2`:** the two-input round-robin arbiter (last-grant register plus grant logic). Tracker and flag logic stay inline.

## Test plan
- **Single add:** requester 0 issues a = 0x3F800000, b = 0x40000000, op 0, tag 5 in cycle 1 → `res_valid_0` in cycle 3, `res_data` = 0x40400000, `res_tag` = 5, and `sticky_flags_0` gains only the bits set in `res_flags`.
- **Contest:** both valid continuously for 6 cycles after reset → grant sequence 0,1,0,1,0,1; results return in the same order 2 cycles later with matching tags.
- **Effective subtraction:** requester 1 issues a = 0x40400000, b = 0x40400000, op 1 → `add_EOP` = 1 in the issue cycle; the result is zero with the zero flag set, and `sticky_flags_1[0]` = 1.
- **Simultaneous clear:** `clr_flags_0` asserted in the same cycle that a result with flags 0b00010 returns, with prior sticky 0b01000 → `sticky_flags_0` = 0b00010.
- **Reset mid-flight:** issue at cycle c, assert `rst` = 0 at cycle c+1 → no `res_valid` at c+2, all outputs at their reset values, and `busy` = 0.
- **Idle:** no requests → `add_*` outputs all 0 and `busy` = 0.
